// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling geometry, receiver states and the
// majority vote used for bit decisions. The transmitter reuses this package.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned SAMPLE_LO  = 3;
    localparam int unsigned SAMPLE_MID = 4;
    localparam int unsigned SAMPLE_HI  = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // 2-of-3 vote over the mid-bit samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks. The counter is
// parked at zero while restart is high, so the tick phase follows the release.
module uart_baud_tick #(
    parameter int unsigned DIV = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    // Count 0..DIV-1 and wrap; reset and restart both park it at zero
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick = (cnt_q == CntMax) && !restart;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, 8x oversampled with 3-sample majority voting. Writes
// each good byte to the downstream FIFO and flags overrun / framing errors.
module uart_rx #(
    parameter int unsigned CLK_HZ = 12_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DIV    = (CLK_HZ + 4 * BAUD) / (8 * BAUD)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       full,
    output logic [7:0] data_out,
    output logic       wr,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    localparam logic [2:0] SubLo   = 3'(SAMPLE_LO);
    localparam logic [2:0] SubMid  = 3'(SAMPLE_MID);
    localparam logic [2:0] SubHi   = 3'(SAMPLE_HI);
    localparam logic [2:0] SubLast = 3'(OVERSAMPLE - 1);

    rx_state_t  state_q, state_d;
    logic [1:0] sync_q;
    logic [2:0] sub_q, sub_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       s_lo_q, s_lo_d;
    logic       s_mid_q, s_mid_d;
    logic       wr_q, wr_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    logic rxd_s;
    logic tick;
    logic decide;
    logic bit_end;
    logic maj;

    assign rxd_s   = sync_q[1];
    assign decide  = tick && (sub_q == SubHi);
    assign bit_end = tick && (sub_q == SubLast);
    assign maj     = majority3(s_lo_q, s_mid_q, rxd_s);

    // Tick phase is pinned to the start edge: the divider idles at zero in IDLE
    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(state_q == IDLE),
        .tick   (tick)
    );

    // Two-flop synchronizer for the asynchronous pin; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            s_lo_q  <= 1'b1;
            s_mid_q <= 1'b1;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            s_lo_q  <= s_lo_d;
            s_mid_q <= s_mid_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: sample capture, bit assembly and frame decisions
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        s_lo_d  = s_lo_q;
        s_mid_d = s_mid_q;
        wr_d    = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (tick) begin
            sub_d = sub_q + 3'd1;
            if (sub_q == SubLo) begin
                s_lo_d = rxd_s;
            end
            if (sub_q == SubMid) begin
                s_mid_d = rxd_s;
            end
        end

        unique case (state_q)
            IDLE: begin
                sub_d = '0;
                bit_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;  // glitch, not a real start bit
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is caught early
                if (decide) begin
                    if (maj) begin
                        state_d = IDLE;
                        if (full) begin
                            ovr_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = shift_q;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line recovers so a break is not read as 0x00
                sub_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign wr        = wr_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule
